ofdm_cp_framer: RTL and testbench
=================================

Name: ofdm_cp_framer

Overview:
- Parametrised guard-interval framer between the IFFT output stream and the channel/FFT side of the OFDM chain.
- Captures each NFFT-sample IFFT symbol into a ping-pong buffer, then emits CP_LEN cyclic-prefix samples followed by the NFFT body samples on a valid/ready stream.
- Adds frame markers, backpressure and overflow detection, which the current IFFT-to-FFT path lacks.

Parameters:
- NFFT, 64, symbol length; power of two, 8..1024.
- CP_LEN, 16, prefix length; 0..NFFT.
- DW, 16, signed width of each of re/im.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_en  in  1  input sample strobe (IFFT do_en style, no backpressure).
- in_re  in  DW  signed input real.
- in_im  in  DW  signed input imaginary.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_re  out  DW  output real.
- out_im  out  DW  output imaginary.
- out_sof  out  1  first sample of framed symbol (first CP sample, or body[0] if CP_LEN=0).
- out_eof  out  1  last body sample.
- overflow  out  1  sticky; symbol dropped.

Behaviour:
- Reset (sync, active-high): out_valid=0, out_re=out_im=0, out_sof=out_eof=0, overflow=0. Both banks empty, wr_bank=rd_bank=0, wr_idx=0, FSM=IDLE. Reset mid-symbol discards all buffered and partial data.
- Write side:
  - Each in_en writes {in_re,in_im} to bank[wr_bank][wr_idx], then wr_idx increments.
  - At wr_idx==NFFT-1: set full[wr_bank], toggle wr_bank, wr_idx=0.
- Drop rule:
  - If in_en arrives with wr_idx==0 and full[wr_bank]=1, the entire incoming symbol (NFFT strobes) is discarded.
  - overflow is set and stays set until reset; wr_idx still counts to keep symbol alignment; wr_bank is not toggled.
  - A bank freed by the read side on the same edge counts as empty (free beats drop).
- Read FSM:
  - IDLE: if full[rd_bank], go to PREFIX with rd_idx=NFFT-CP_LEN, or to BODY with rd_idx=0 if CP_LEN=0.
  - PREFIX: present bank[rd_bank][rd_idx]. On out_valid&&out_ready, rd_idx++. After the CP_LEN-th accept, go to BODY with rd_idx=0.
  - BODY: present body samples 0..NFFT-1. On the last accept, clear full[rd_bank] and toggle rd_bank. Then go to PREFIX/BODY directly if the other bank is full (no bubble), else IDLE.
- Output stream:
  - out_valid=1 in PREFIX and BODY.
  - Data, sof and eof are held stable while out_valid&&!out_ready.
  - Framed symbol length is CP_LEN+NFFT accepted samples.
- Latency: with out_ready=1, out_valid rises 2 rising edges after the edge that samples the last in_en of a symbol.
- Throughput: sustained with out_ready=1 when the input averages at most NFFT strobes per CP_LEN+NFFT cycles; otherwise overflow.
- Widths: no arithmetic; data passes bit-exact.

Optional Feature:
- Macro OFDM_ZERO_GUARD_EN.
- Defined: PREFIX emits CP_LEN zero samples (zero-padded guard) instead of copied tail samples; handshake, sof and counts are unchanged.
- Undefined: cyclic prefix as above.

Decomposition:
- Shared package ofdm_pkg holds:
  - DW default, NFFT/CP_LEN defaults;
  - the FSM state encoding (IDLE, PREFIX, BODY);
  - the complex-sample pair type.
- One natural sub-module, ofdm_pingpong_buf: two NFFT x 2DW register banks with full flags, write pointer and drop logic.
- The FSM and output registers stay in ofdm_cp_framer.

Test Plan:
- Single symbol: ramp re=k, im=-k (k=0..63), out_ready=1. Expect 80 samples: re=48..63 then 0..63; sof on first, eof on last; out_valid 2 edges after last in_en.
- Back-to-back: 4 symbols with in_en asserted 64 of every 80 cycles, out_ready=1. Expect 320 contiguous valid samples, no bubble between frames, overflow=0.
- Backpressure: out_ready toggled pseudo-randomly. Data, sof and eof held stable while stalled; sequence identical to the no-stall run.
- Overflow: out_ready=0, feed 3 symbols. Symbols 1-2 buffered, symbol 3 dropped, overflow=1. Release out_ready: exactly symbols 1 and 2 are emitted.
- CP_LEN=0 and CP_LEN=NFFT builds. Expect 64 samples with sof on body[0]; and 128 samples where the prefix equals the whole body.
- Reset mid-body output and mid-input symbol. Outputs go to 0 next edge; the next full input symbol frames correctly. With OFDM_ZERO_GUARD_EN, the first 16 samples are 0.

Source files
------------

// File: rtl/ofdm_cp_framer_pkg.sv
// Shared defaults, read-FSM state encoding and complex-sample type for the OFDM
// cyclic-prefix framer and its ping-pong buffer.
package ofdm_pkg;

  localparam int NFFT_DEF   = 64;
  localparam int CP_LEN_DEF = 16;
  localparam int DW_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_BODY
  } framerState_t;

  // Packed {re, im} pair at the default width; the RTL carries it as a 2*DW vector.
  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/ofdm_cp_framer_if.sv
// Sample-in / framed-sample-out bundle of the OFDM cyclic-prefix framer.
// The master drives IFFT samples and out_ready; the slave is the framer.
interface ofdm_cp_framer_if
  import ofdm_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic                 in_en;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_sof;
  logic                 out_eof;
  logic                 overflow;

  modport master (
    output in_en, in_re, in_im, out_ready,
    input  out_valid, out_re, out_im, out_sof, out_eof, overflow
  );

  modport slave (
    input  in_en, in_re, in_im, out_ready,
    output out_valid, out_re, out_im, out_sof, out_eof, overflow
  );

endinterface

// File: rtl/ofdm_cp_framer_pingpong_buf.sv
// Two NFFT-deep sample banks with per-bank full flags, the write pointer and the
// whole-symbol drop rule that raises a sticky overflow.
module ofdm_pingpong_buf
  import ofdm_pkg::*;
#(
  parameter  int NFFT = NFFT_DEF,
  parameter  int DW   = DW_DEF,
  localparam int AW   = $clog2(NFFT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wrEn_i,
  input  logic [2*DW-1:0] wrData_i,
  input  logic            rdBank_i,
  input  logic [AW-1:0]   rdIdx_i,
  input  logic            free_i,
  output logic [2*DW-1:0] rdData_o,
  output logic [1:0]      full_o,
  output logic            overflow_o
);

  logic [2*DW-1:0] mem [2][NFFT];
  logic [1:0]      full_q, full_d;
  logic            wrBank_q, wrBank_d;
  logic [AW-1:0]   wrIdx_q, wrIdx_d;
  logic            dropping_q, dropping_d;
  logic            overflow_q, overflow_d;
  logic            freedHere;
  logic            dropSym;
  logic            symEnd;

  // The drop decision is taken on the first strobe of a symbol and held for the rest;
  // a bank released by the reader on that same edge already counts as empty.
  always_comb begin
    freedHere  = free_i && (rdBank_i == wrBank_q);
    dropSym    = (wrIdx_q == '0) ? (full_q[wrBank_q] && !freedHere) : dropping_q;
    symEnd     = (wrIdx_q == AW'(NFFT - 1));
    full_d     = full_q;
    wrBank_d   = wrBank_q;
    wrIdx_d    = wrIdx_q;
    dropping_d = dropping_q;
    overflow_d = overflow_q;
    if (free_i) begin
      full_d[rdBank_i] = 1'b0;
    end
    if (wrEn_i) begin
      wrIdx_d    = wrIdx_q + 1'b1;
      dropping_d = dropSym;
      if (dropSym) begin
        overflow_d = 1'b1;
      end
      if (symEnd && !dropSym) begin
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = ~wrBank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= '0;
      wrBank_q   <= 1'b0;
      wrIdx_q    <= '0;
      dropping_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wrBank_q   <= wrBank_d;
      wrIdx_q    <= wrIdx_d;
      dropping_q <= dropping_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn_i && !dropSym) begin
      mem[wrBank_q][wrIdx_q] <= wrData_i;
    end
  end

  assign rdData_o   = mem[rdBank_i][rdIdx_i];
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ofdm_cp_framer.sv
// OFDM guard-interval framer: buffers IFFT symbols and emits CP_LEN prefix + NFFT body
// samples on a valid/ready stream. Define OFDM_ZERO_GUARD_EN for a zero-padded guard.
module ofdm_cp_framer
  import ofdm_pkg::*;
#(
  parameter int NFFT   = NFFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int DW     = DW_DEF
) (
  input logic             clk,
  input logic             reset,
  ofdm_cp_framer_if.slave bus
);

  localparam int             AW          = $clog2(NFFT);
  localparam logic [AW-1:0]  LAST_IDX    = AW'(NFFT - 1);
  localparam logic [AW-1:0]  CP_START    = AW'(NFFT - CP_LEN);
  localparam framerState_t   FIRST_STATE = (CP_LEN == 0) ? ST_BODY : ST_PREFIX;
  localparam logic [AW-1:0]  FIRST_IDX   = (CP_LEN == 0) ? '0 : CP_START;

  framerState_t    state_q;
  logic            rdBank_q;
  logic [AW-1:0]   rdIdx_q;
  logic            outValid_q, outSof_q, outEof_q;
  logic [DW-1:0]   outRe_q, outIm_q;
  logic [1:0]      full;
  logic [2*DW-1:0] rdData, fetchData;
  logic            overflow;
  logic            load, fetch, freeBank, otherFull, fetchSof;

  ofdm_pingpong_buf #(.NFFT(NFFT), .DW(DW)) uBuf (
    .clk       (clk),
    .reset     (reset),
    .wrEn_i    (bus.in_en),
    .wrData_i  ({bus.in_re, bus.in_im}),
    .rdBank_i  (rdBank_q),
    .rdIdx_i   (rdIdx_q),
    .free_i    (freeBank),
    .rdData_o  (rdData),
    .full_o    (full),
    .overflow_o(overflow)
  );

  // The FSM points at the next sample to fetch; the output register takes it whenever
  // it is empty or being accepted, so the bank is released as its last sample is fetched.
  assign load      = !outValid_q || bus.out_ready;
  assign fetch     = load && (state_q != ST_IDLE);
  assign freeBank  = fetch && (state_q == ST_BODY) && (rdIdx_q == LAST_IDX);
  assign otherFull = full[~rdBank_q];
  assign fetchSof  = ((state_q == ST_PREFIX) && (rdIdx_q == CP_START)) ||
                     ((CP_LEN == 0) && (state_q == ST_BODY) && (rdIdx_q == '0));

  always_comb begin
    fetchData = rdData;
`ifdef OFDM_ZERO_GUARD_EN
    if (state_q == ST_PREFIX) begin
      fetchData = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rdBank_q   <= 1'b0;
      rdIdx_q    <= '0;
      outValid_q <= 1'b0;
      outSof_q   <= 1'b0;
      outEof_q   <= 1'b0;
      outRe_q    <= '0;
      outIm_q    <= '0;
    end else begin
      if (load) begin
        outValid_q <= fetch;
        outSof_q   <= fetch && fetchSof;
        outEof_q   <= freeBank;
        if (fetch) begin
          outRe_q <= fetchData[2*DW-1:DW];
          outIm_q <= fetchData[DW-1:0];
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (full[rdBank_q]) begin
            state_q <= FIRST_STATE;
            rdIdx_q <= FIRST_IDX;
          end
        end
        ST_PREFIX: begin
          if (fetch) begin
            rdIdx_q <= rdIdx_q + 1'b1;
            if (rdIdx_q == LAST_IDX) begin
              state_q <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (fetch) begin
            if (rdIdx_q == LAST_IDX) begin
              rdBank_q <= ~rdBank_q;
              if (otherFull) begin
                state_q <= FIRST_STATE;
                rdIdx_q <= FIRST_IDX;
              end else begin
                state_q <= ST_IDLE;
                rdIdx_q <= '0;
              end
            end else begin
              rdIdx_q <= rdIdx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_re    = outRe_q;
  assign bus.out_im    = outIm_q;
  assign bus.out_sof   = outSof_q;
  assign bus.out_eof   = outEof_q;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_ofdm_cp_framer.sv
// Bench for ofdm_cp_framer: random and ramp symbols checked against a frame-level model,
// with CP_LEN=16, CP_LEN=0 and CP_LEN=NFFT instances sharing one input stream.
`timescale 1ns/1ps
module tb_ofdm_cp_framer;
  import ofdm_pkg::*;

  localparam int NFFT = 64;
  localparam int CP   = 16;
  localparam int DW   = 16;

  typedef struct packed {
    logic          sof;
    logic          eof;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } beat_t;
  typedef beat_t beatQ_t[$];
  typedef cplx_t symbol_t [NFFT];

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 inEn = 1'b0;
  logic signed [DW-1:0] inRe = '0;
  logic signed [DW-1:0] inIm = '0;
  logic                 outReady = 1'b1;
  logic                 randReady = 1'b0;

  int     compared = 0;
  int     mismatched = 0;
  int     cycle = 0;
  int     validCount = 0;
  int     firstValid = -1;
  int     lastValid = -1;
  beatQ_t gotM, got0, gotF;
  beat_t  curM, prevM;
  logic   prevStall = 1'b0;
  logic   prevReset = 1'b1;

  ofdm_cp_framer_if #(.DW(DW)) ifM ();
  ofdm_cp_framer_if #(.DW(DW)) if0 ();
  ofdm_cp_framer_if #(.DW(DW)) ifF ();

  assign ifM.in_en = inEn;  assign ifM.in_re = inRe;  assign ifM.in_im = inIm;  assign ifM.out_ready = outReady;
  assign if0.in_en = inEn;  assign if0.in_re = inRe;  assign if0.in_im = inIm;  assign if0.out_ready = outReady;
  assign ifF.in_en = inEn;  assign ifF.in_re = inRe;  assign ifF.in_im = inIm;  assign ifF.out_ready = outReady;

  ofdm_cp_framer #(.NFFT(NFFT), .CP_LEN(CP),   .DW(DW)) dutM (.clk(clk), .reset(reset), .bus(ifM));
  ofdm_cp_framer #(.NFFT(NFFT), .CP_LEN(0),    .DW(DW)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  ofdm_cp_framer #(.NFFT(NFFT), .CP_LEN(NFFT), .DW(DW)) dutF (.clk(clk), .reset(reset), .bus(ifF));

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  // Pseudo-random downstream stalls, changed just after each edge like every other input.
  always @(posedge clk) begin
    if (randReady) begin
      #1 outReady = 1'($urandom_range(0, 1));
    end
  end

  // Collect accepted beats, and require a stalled beat to be presented again unchanged.
  always @(negedge clk) begin
    curM = {ifM.out_sof, ifM.out_eof, ifM.out_re, ifM.out_im};
    if (prevStall && !prevReset) begin
      compared++;
      assert (ifM.out_valid === 1'b1 && curM === prevM)
        else begin
          mismatched++;
          $error("[TB] FAIL stall_hold observed=%h/%b expected=%h/1", curM, ifM.out_valid, prevM);
        end
    end
    prevStall = ifM.out_valid && !outReady;
    prevM     = curM;
    prevReset = reset;
    if (!reset && ifM.out_valid && outReady) gotM.push_back(curM);
    if (!reset && if0.out_valid && outReady) got0.push_back({if0.out_sof, if0.out_eof, if0.out_re, if0.out_im});
    if (!reset && ifF.out_valid && outReady) gotF.push_back({ifF.out_sof, ifF.out_eof, ifF.out_re, ifF.out_im});
    if (ifM.out_valid) begin
      if (firstValid < 0) firstValid = cycle;
      lastValid = cycle;
      validCount++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    inEn  = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    gotM.delete();
    got0.delete();
    gotF.delete();
    validCount = 0;
    firstValid = -1;
    lastValid  = -1;
  endtask

  // mode 0: ramp re=k, im=-k; otherwise uniformly random samples.
  task automatic makeSymbol(input int mode, output symbol_t s);
    for (int k = 0; k < NFFT; k++) begin
      if (mode == 0) begin
        s[k].re = 16'(k);
        s[k].im = 16'(-k);
      end else begin
        s[k].re = 16'($urandom);
        s[k].im = 16'($urandom);
      end
    end
  endtask

  task automatic applyStimulus(input symbol_t s, input int gap);
    for (int k = 0; k < NFFT; k++) begin
      inEn = 1'b1;
      inRe = s[k].re;
      inIm = s[k].im;
      tick();
    end
    inEn = 1'b0;
    repeat (gap) tick();
  endtask

  // Framed symbol: guard of cp samples (the symbol tail, or zeros), then the whole body.
  task automatic buildFrame(input symbol_t s, input int cp, output beatQ_t fr);
    cplx_t v;
    fr.delete();
    for (int j = 0; j < cp + NFFT; j++) begin
      if (j < cp) v = s[NFFT - cp + j];
      else        v = s[j - cp];
`ifdef OFDM_ZERO_GUARD_EN
      if (j < cp) v = '0;
`endif
      fr.push_back({(j == 0), (j == cp + NFFT - 1), v.re, v.im});
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkStream(input string tag, input beatQ_t exp, input beatQ_t got);
    int n;
    compared++;
    assert (got.size() === exp.size())
      else begin
        mismatched++;
        $error("[TB] FAIL %s_len observed=%0d expected=%0d", tag, got.size(), exp.size());
      end
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      compared++;
      assert (got[i] === exp[i])
        else begin
          mismatched++;
          $error("[TB] FAIL %s[%0d] observed=%h expected=%h", tag, i, got[i], exp[i]);
        end
    end
  endtask

  task automatic waitBeats(input string tag, input int nM, input int budget);
    int b = 0;
    while (gotM.size() < nM && b < budget) begin
      tick();
      b++;
    end
    checkOutput({tag, "_timeout"}, 32'(gotM.size() >= nM), 32'd1);
  endtask

  symbol_t s1, s2, s3, s4;
  beatQ_t  expM, exp0, expF, fr;
  int      n;

  initial begin
    $display("[TB] start NFFT=%0d CP_LEN=%0d", NFFT, CP);

    // Reset state and a single ramp symbol through all three prefix lengths.
    outReady = 1'b1;
    doReset();
    checkOutput("rst_valid", 32'(ifM.out_valid), 32'd0);
    checkOutput("rst_re",    32'(ifM.out_re),    32'd0);
    checkOutput("rst_im",    32'(ifM.out_im),    32'd0);
    checkOutput("rst_sof",   32'(ifM.out_sof),   32'd0);
    checkOutput("rst_eof",   32'(ifM.out_eof),   32'd0);
    checkOutput("rst_ovf",   32'(ifM.overflow),  32'd0);
    makeSymbol(0, s1);
    applyStimulus(s1, 0);
    n = 0;
    while (!ifM.out_valid && n < 10) begin
      tick();
      n++;
    end
    checkOutput("latency", 32'(n), 32'd2);
    waitBeats("single", NFFT + CP, 300);
    repeat (100) tick();
    buildFrame(s1, CP, expM);
    buildFrame(s1, 0, exp0);
    buildFrame(s1, NFFT, expF);
    checkStream("single", expM, gotM);
    checkStream("cp0", exp0, got0);
    checkStream("cpfull", expF, gotF);

    // Back-to-back: 64 strobes every 80 cycles must give one unbroken valid run.
    doReset();
    makeSymbol(1, s1);
    makeSymbol(1, s2);
    makeSymbol(1, s3);
    makeSymbol(1, s4);
    applyStimulus(s1, CP);
    applyStimulus(s2, CP);
    applyStimulus(s3, CP);
    applyStimulus(s4, CP);
    waitBeats("b2b", 4 * (NFFT + CP), 400);
    repeat (5) tick();
    buildFrame(s1, CP, expM);
    buildFrame(s2, CP, fr);  expM = {expM, fr};
    buildFrame(s3, CP, fr);  expM = {expM, fr};
    buildFrame(s4, CP, fr);  expM = {expM, fr};
    checkStream("b2b", expM, gotM);
    checkOutput("b2b_valid_count", 32'(validCount), 32'(4 * (NFFT + CP)));
    checkOutput("b2b_contiguous", 32'(lastValid - firstValid + 1), 32'(4 * (NFFT + CP)));
    checkOutput("b2b_ovf", 32'(ifM.overflow), 32'd0);

    // Random backpressure: content identical to the unstalled case.
    doReset();
    randReady = 1'b1;
    makeSymbol(1, s1);
    makeSymbol(1, s2);
    makeSymbol(1, s3);
    applyStimulus(s1, 0);
    waitBeats("bp1", 1 * (NFFT + CP), 1500);
    applyStimulus(s2, 0);
    waitBeats("bp2", 2 * (NFFT + CP), 1500);
    applyStimulus(s3, 0);
    waitBeats("bp3", 3 * (NFFT + CP), 1500);
    randReady = 1'b0;
    #2;
    outReady = 1'b1;
    buildFrame(s1, CP, expM);
    buildFrame(s2, CP, fr);  expM = {expM, fr};
    buildFrame(s3, CP, fr);  expM = {expM, fr};
    checkStream("bp", expM, gotM);
    checkOutput("bp_ovf", 32'(ifM.overflow), 32'd0);

    // Overflow: with the output blocked the third symbol finds both banks full.
    outReady = 1'b0;
    doReset();
    makeSymbol(1, s1);
    makeSymbol(1, s2);
    makeSymbol(1, s3);
    applyStimulus(s1, 0);
    applyStimulus(s2, 0);
    checkOutput("ovf_after_two", 32'(ifM.overflow), 32'd0);
    applyStimulus(s3, 0);
    checkOutput("ovf_after_three", 32'(ifM.overflow), 32'd1);
    outReady = 1'b1;
    waitBeats("ovf", 2 * (NFFT + CP), 600);
    repeat (120) tick();
    buildFrame(s1, CP, expM);
    buildFrame(s2, CP, fr);  expM = {expM, fr};
    checkStream("ovf", expM, gotM);
    checkOutput("ovf_sticky", 32'(ifM.overflow), 32'd1);

    // Reset while a frame is in its body and the next symbol is half written.
    outReady = 1'b1;
    doReset();
    makeSymbol(1, s1);
    makeSymbol(1, s2);
    applyStimulus(s1, 0);
    for (int k = 0; k < 30; k++) begin
      inEn = 1'b1;
      inRe = s2[k].re;
      inIm = s2[k].im;
      tick();
    end
    inEn = 1'b0;
    checkOutput("pre_rst_in_body", 32'(gotM.size() > CP), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_valid", 32'(ifM.out_valid), 32'd0);
    checkOutput("midrst_re",    32'(ifM.out_re),    32'd0);
    checkOutput("midrst_im",    32'(ifM.out_im),    32'd0);
    checkOutput("midrst_sof",   32'(ifM.out_sof),   32'd0);
    checkOutput("midrst_eof",   32'(ifM.out_eof),   32'd0);
    doReset();
    makeSymbol(1, s3);
    applyStimulus(s3, 0);
    waitBeats("postrst", NFFT + CP, 300);
    repeat (20) tick();
    buildFrame(s3, CP, expM);
    checkStream("postrst", expM, gotM);
    checkOutput("postrst_ovf", 32'(ifM.overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
